slc3_control: RTL and testbench
===============================

SLC3_CONTROL -- requirements
Module: slc3_control

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset; low forces HALTED state immediately.
REQ-003 Run  input  1  start request; sampled only in HALTED.
REQ-004 Continue  input  1  resume request; sampled only in PAUSE_IR1/PAUSE_IR2.
REQ-005 Opcode  input  4  IR[15:12] of the current instruction.
REQ-006 IR_5  input  1  immediate-mode bit for ADD/AND.
REQ-007 BEN  input  1  registered branch-enable, valid from the cycle after LD_BEN.
REQ-008 Mem_Ready  input  1  memory completion strobe for read/write cycles.
REQ-009 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC  output  1 each  register load enables.
REQ-010 GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers; at most one high per cycle.
REQ-011 PCMUX  output  2  00 PC+1, 01 bus, 10 adder.
REQ-012 DRMUX, SR1MUX, SR2MUX, ADDR1MUX  output  1 each  datapath mux selects.
REQ-013 ADDR2MUX  output  2  00 zero, 01 offset6, 10 offset9, 11 offset11.
REQ-014 ALUK  output  2  ALU op: 00 ADD, 01 AND, 10 NOT, 11 pass X.
REQ-015 Mem_RD, Mem_WR  output  1 each  memory read/write requests, active-high.

Function
REQ-016 Moore FSM; all outputs decoded from current state only; every output defaults 0 in every state unless listed.
REQ-017 HALTED: hold; Run=1 -> FETCH1.
REQ-018 FETCH1: GatePC, LD_MAR, PCMUX=00, LD_PC -> FETCH2.
REQ-019 FETCH2: Mem_RD, LD_MDR; stay until Mem_Ready=1, then -> FETCH3.
REQ-020 FETCH3: GateMDR, LD_IR -> DECODE.
REQ-021 DECODE: LD_BEN; Opcode 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0110 LDR, 0111 STR, 1101 PAUSE_IR1; any other opcode -> FETCH1 (treated as NOP).
REQ-022 ADD/AND: GateALU, LD_REG, LD_CC, ALUK=00/01, SR2MUX=IR_5 -> FETCH1.
REQ-023 NOT: GateALU, LD_REG, LD_CC, ALUK=10 -> FETCH1.
REQ-024 BR: BEN=1 -> BR_TAKEN, else FETCH1; BR_TAKEN: LD_PC, PCMUX=10, ADDR1MUX=0 (PC), ADDR2MUX=10 -> FETCH1.
REQ-025 JMP: LD_PC, PCMUX=10, ADDR1MUX=1 (BaseR), ADDR2MUX=00 -> FETCH1.
REQ-026 LDR: LDR1 (GateMARMUX, LD_MAR, ADDR1MUX=1, ADDR2MUX=01) -> LDR2 (Mem_RD, LD_MDR, wait Mem_Ready) -> LDR3 (GateMDR, LD_REG, LD_CC) -> FETCH1.
REQ-027 STR: STR1 (as LDR1) -> STR2 (GateALU, ALUK=11, SR1MUX=1, LD_MDR) -> STR3 (Mem_WR, hold until Mem_Ready) -> FETCH1.
REQ-028 PAUSE_IR1: hold while Continue=0; Continue=1 -> PAUSE_IR2; PAUSE_IR2: hold while Continue=1; Continue=0 -> FETCH1 (one instruction per press).
REQ-029 Mem_Ready asserted outside FETCH2/LDR2/STR3 ignored; memory request held continuously while waiting (no timeout).
REQ-030 Minimum latency: ALU op 5 cycles, BR taken 6, LDR 7, STR 7, with Mem_Ready=1 on first wait cycle.

Reset
REQ-031 Reset low: state=HALTED asynchronously; all outputs 0 (ALUK=00, PCMUX=00, ADDR2MUX=00) same cycle.
REQ-032 Reset mid-memory-cycle abandons the access; Mem_RD/Mem_WR drop with reset, no completion.
REQ-033 After Reset released, FSM leaves HALTED only on a rising edge with Run=1.

Structure
REQ-034 Shared package slc3_pkg holds state enum, opcode constants, ALUK/PCMUX/ADDR2MUX encodings (ALUK values shared with the ALU).
REQ-035 Single module; no sub-modules; next-state and output logic in separate combinational blocks, one state register.

Verification
REQ-036 Reset low in STR3 -> Mem_WR=0 immediately, state HALTED, all outputs 0.
REQ-037 Run=1, Opcode=0001, IR_5=1, Mem_Ready=1 -> FETCH1,FETCH2,FETCH3,DECODE,ADD; ADD cycle GateALU=1, ALUK=00, SR2MUX=1, LD_REG=LD_CC=1.
REQ-038 Opcode=0000, BEN=0 -> BR then FETCH1, LD_PC never set; BEN=1 -> BR_TAKEN with PCMUX=10, ADDR2MUX=10.
REQ-039 LDR with Mem_Ready held 0 for 3 cycles in LDR2 -> Mem_RD high 4 cycles, LD_MDR high throughout, then LDR3.
REQ-040 Opcode=1101, Continue held 1 for 10 cycles then 0 -> exactly one FETCH1 entry after release.
REQ-041 Opcode=1010 (unsupported) -> DECODE then FETCH1, no LD_REG/LD_PC/Mem_WR asserted.

Source files
------------

// File: rtl/slc3_pkg.sv
// Shared definitions for the SLC-3 control unit: FSM states, opcodes and
// datapath select encodings (ALUK values are also used by the ALU).
package slc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR,
        S_BR_TAKEN,
        S_JMP,
        S_LDR1,
        S_LDR2,
        S_LDR3,
        S_STR1,
        S_STR2,
        S_STR3,
        S_PAUSE_IR1,
        S_PAUSE_IR2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

endpackage

// File: rtl/slc3_control.sv
// SLC-3 control unit: Moore FSM sequencing fetch, decode and execute of
// ADD/AND/NOT/BR/JMP/LDR/STR/PAUSE; every output is decoded from the state.
module slc3_control
    import slc3_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       BEN,
    input  logic       Mem_Ready,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_RD,
    output logic       Mem_WR
);

    state_t state;
    state_t next_state;

    // State register; reset drops to HALTED at once, abandoning any memory cycle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_HALTED;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; memory waits hold until Mem_Ready, pause needs a full press/release
    always_comb begin
        next_state = state;
        case (state)
            S_HALTED:    if (Run) next_state = S_FETCH1;
            S_FETCH1:    next_state = S_FETCH2;
            S_FETCH2:    if (Mem_Ready) next_state = S_FETCH3;
            S_FETCH3:    next_state = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_ADD:   next_state = S_ADD;
                    OP_AND:   next_state = S_AND;
                    OP_NOT:   next_state = S_NOT;
                    OP_BR:    next_state = S_BR;
                    OP_JMP:   next_state = S_JMP;
                    OP_LDR:   next_state = S_LDR1;
                    OP_STR:   next_state = S_STR1;
                    OP_PAUSE: next_state = S_PAUSE_IR1;
                    default:  next_state = S_FETCH1;
                endcase
            end
            S_ADD:       next_state = S_FETCH1;
            S_AND:       next_state = S_FETCH1;
            S_NOT:       next_state = S_FETCH1;
            S_BR:        next_state = BEN ? S_BR_TAKEN : S_FETCH1;
            S_BR_TAKEN:  next_state = S_FETCH1;
            S_JMP:       next_state = S_FETCH1;
            S_LDR1:      next_state = S_LDR2;
            S_LDR2:      if (Mem_Ready) next_state = S_LDR3;
            S_LDR3:      next_state = S_FETCH1;
            S_STR1:      next_state = S_STR2;
            S_STR2:      next_state = S_STR3;
            S_STR3:      if (Mem_Ready) next_state = S_FETCH1;
            S_PAUSE_IR1: if (Continue) next_state = S_PAUSE_IR2;
            S_PAUSE_IR2: if (!Continue) next_state = S_FETCH1;
            default:     next_state = S_HALTED;
        endcase
    end

    // Output decode; everything idles at zero unless the state drives it
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PCMUX_INC;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        Mem_RD     = 1'b0;
        Mem_WR     = 1'b0;
        case (state)
            S_FETCH1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                PCMUX  = PCMUX_INC;
            end
            S_FETCH2, S_LDR2: begin
                Mem_RD = 1'b1;
                LD_MDR = 1'b1;
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_DECODE: LD_BEN = 1'b1;
            S_ADD, S_AND: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                ALUK    = (state == S_AND) ? ALUK_AND : ALUK_ADD;
                SR2MUX  = IR_5;
            end
            S_NOT: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                ALUK    = ALUK_NOT;
            end
            S_BR_TAKEN: begin
                LD_PC    = 1'b1;
                PCMUX    = PCMUX_ADDER;
                ADDR1MUX = 1'b0;
                ADDR2MUX = ADDR2_OFF9;
            end
            S_JMP: begin
                LD_PC    = 1'b1;
                PCMUX    = PCMUX_ADDER;
                ADDR1MUX = 1'b1;
                ADDR2MUX = ADDR2_ZERO;
            end
            S_LDR1, S_STR1: begin
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_OFF6;
            end
            S_LDR3: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_STR2: begin
                GateALU = 1'b1;
                ALUK    = ALUK_PASS;
                SR1MUX  = 1'b1;
                LD_MDR  = 1'b1;
            end
            S_STR3: Mem_WR = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slc3_control.sv
// Self-checking bench for slc3_control: a directed vector table, hand-written
// corner sequences, and randomized instruction streams against a trace model.
module tb_slc3_control;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       BEN;
    logic       Mem_Ready;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_RD, Mem_WR;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_rd, mem_wr;
    } outs_t;

    // Cycle kinds seen from outside; PH_IDLE covers halt, branch test and pause
    typedef enum {
        PH_IDLE, PH_F1, PH_F2, PH_F3, PH_DEC, PH_ADD, PH_AND, PH_NOT,
        PH_BRT, PH_JMP, PH_ADR, PH_LDR2, PH_LDR3, PH_STR2, PH_STR3
    } phase_t;

    typedef struct {
        logic       run;
        logic       cont;
        logic [3:0] op;
        logic       ir5;
        logic       ben;
        logic       mr;
        phase_t     ph;
    } vec_t;

    outs_t act;
    assign act = outs_t'({LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                          GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
                          DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
                          Mem_RD, Mem_WR});

    int vec_count     = 0;
    int miscompares   = 0;
    int mem_rd_cycles = 0;
    int ld_mdr_cycles = 0;
    int gate_pc_cycles = 0;

    logic [3:0] cur_op;
    logic       cur_ir5;
    logic       cur_ben;
    vec_t       vecs[$];

    slc3_control dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
        .Opcode(Opcode), .IR_5(IR_5), .BEN(BEN), .Mem_Ready(Mem_Ready),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
        .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .Mem_RD(Mem_RD), .Mem_WR(Mem_WR)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Expected control word for each externally visible cycle kind
    function automatic outs_t expect_of(input phase_t ph, input logic ir5);
        outs_t o;
        o = '0;
        case (ph)
            PH_F1:   begin o.gate_pc = 1; o.ld_mar = 1; o.ld_pc = 1; o.pcmux = 2'b00; end
            PH_F2:   begin o.mem_rd = 1; o.ld_mdr = 1; end
            PH_F3:   begin o.gate_mdr = 1; o.ld_ir = 1; end
            PH_DEC:  o.ld_ben = 1;
            PH_ADD:  begin o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.aluk = 2'b00; o.sr2mux = ir5; end
            PH_AND:  begin o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.aluk = 2'b01; o.sr2mux = ir5; end
            PH_NOT:  begin o.gate_alu = 1; o.ld_reg = 1; o.ld_cc = 1; o.aluk = 2'b10; end
            PH_BRT:  begin o.ld_pc = 1; o.pcmux = 2'b10; o.addr1mux = 0; o.addr2mux = 2'b10; end
            PH_JMP:  begin o.ld_pc = 1; o.pcmux = 2'b10; o.addr1mux = 1; o.addr2mux = 2'b00; end
            PH_ADR:  begin o.gate_marmux = 1; o.ld_mar = 1; o.addr1mux = 1; o.addr2mux = 2'b01; end
            PH_LDR2: begin o.mem_rd = 1; o.ld_mdr = 1; end
            PH_LDR3: begin o.gate_mdr = 1; o.ld_reg = 1; o.ld_cc = 1; end
            PH_STR2: begin o.gate_alu = 1; o.aluk = 2'b11; o.sr1mux = 1; o.ld_mdr = 1; end
            PH_STR3: o.mem_wr = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic applyStimulus(input logic run, input logic cont, input logic [3:0] op,
                                 input logic ir5, input logic ben, input logic mr);
        Run       = run;
        Continue  = cont;
        Opcode    = op;
        IR_5      = ir5;
        BEN       = ben;
        Mem_Ready = mr;
    endtask

    task automatic checkOutput(input string tag, input outs_t exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %06h expected %06h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_count(input string tag, input int got, input int want);
        vec_count++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Inputs are already applied; check the settled outputs, then advance one clock
    task automatic tick(input string tag, input outs_t exp);
        #2;
        checkOutput(tag, exp);
        if (Mem_RD === 1'b1) mem_rd_cycles++;
        if (LD_MDR === 1'b1) ld_mdr_cycles++;
        if (GatePC === 1'b1) gate_pc_cycles++;
        @(posedge Clk);
        #1;
    endtask

    task automatic step(input string tag, input phase_t ph, input logic mr, input logic cont);
        applyStimulus(1'($urandom_range(0, 1)), cont, cur_op, cur_ir5, cur_ben, mr);
        tick(tag, expect_of(ph, cur_ir5));
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Plays one instruction from FETCH1 back to the next FETCH1 boundary
    task automatic run_instr(input logic [3:0] op, input logic ir5, input logic ben,
                             input int fetch_stall, input int mem_stall,
                             input int hold1, input int hold2);
        cur_op  = op;
        cur_ir5 = ir5;
        cur_ben = ben;
        step("fetch1", PH_F1, rbit(), rbit());
        for (int i = 0; i < fetch_stall; i++) step("fetch2_wait", PH_F2, 1'b0, rbit());
        step("fetch2", PH_F2, 1'b1, rbit());
        step("fetch3", PH_F3, rbit(), rbit());
        step("decode", PH_DEC, rbit(), rbit());
        case (op)
            4'b0001: step("add", PH_ADD, rbit(), rbit());
            4'b0101: step("and", PH_AND, rbit(), rbit());
            4'b1001: step("not", PH_NOT, rbit(), rbit());
            4'b0000: begin
                step("br", PH_IDLE, rbit(), rbit());
                if (ben) step("br_taken", PH_BRT, rbit(), rbit());
            end
            4'b1100: step("jmp", PH_JMP, rbit(), rbit());
            4'b0110: begin
                step("ldr1", PH_ADR, rbit(), rbit());
                for (int i = 0; i < mem_stall; i++) step("ldr2_wait", PH_LDR2, 1'b0, rbit());
                step("ldr2", PH_LDR2, 1'b1, rbit());
                step("ldr3", PH_LDR3, rbit(), rbit());
            end
            4'b0111: begin
                step("str1", PH_ADR, rbit(), rbit());
                step("str2", PH_STR2, rbit(), rbit());
                for (int i = 0; i < mem_stall; i++) step("str3_wait", PH_STR3, 1'b0, rbit());
                step("str3", PH_STR3, 1'b1, rbit());
            end
            4'b1101: begin
                for (int i = 0; i < hold1; i++) step("pause1_wait", PH_IDLE, rbit(), 1'b0);
                step("pause1", PH_IDLE, rbit(), 1'b1);
                for (int i = 0; i < hold2; i++) step("pause2_wait", PH_IDLE, rbit(), 1'b1);
                step("pause2", PH_IDLE, rbit(), 1'b0);
            end
            default: ;
        endcase
    endtask

    // Reset, check the halted outputs, release, then press Run for one cycle
    task automatic reset_and_start();
        Reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        tick("reset_held", expect_of(PH_IDLE, 1'b0));
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        tick("halted_no_run", expect_of(PH_IDLE, 1'b0));
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick("halted_run", expect_of(PH_IDLE, 1'b0));
    endtask

    task automatic add_vec(input logic run, input logic cont, input logic [3:0] op,
                           input logic ir5, input logic ben, input logic mr, input phase_t ph);
        vec_t v;
        v.run = run; v.cont = cont; v.op = op; v.ir5 = ir5;
        v.ben = ben; v.mr = mr; v.ph = ph;
        vecs.push_back(v);
    endtask

    initial begin
        Reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        cur_op = 4'h0; cur_ir5 = 1'b0; cur_ben = 1'b0;
        @(posedge Clk);
        #1;

        // Directed table: each row is the inputs of one cycle and that cycle's outputs
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_IDLE);
        add_vec(0, 1, 4'hF, 0, 0, 0, PH_IDLE);
        add_vec(1, 0, 4'hF, 0, 0, 0, PH_IDLE);
        add_vec(1, 1, 4'hF, 0, 0, 1, PH_F1);
        add_vec(0, 0, 4'hF, 0, 0, 0, PH_F2);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F2);
        add_vec(0, 0, 4'hF, 0, 0, 0, PH_F3);
        add_vec(0, 0, 4'b0001, 1, 0, 0, PH_DEC);
        add_vec(0, 0, 4'b0001, 1, 0, 0, PH_ADD);
        add_vec(1, 0, 4'hF, 0, 0, 0, PH_F1);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F2);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F3);
        add_vec(0, 0, 4'b0101, 0, 0, 1, PH_DEC);
        add_vec(0, 0, 4'b0101, 0, 0, 1, PH_AND);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F1);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F2);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F3);
        add_vec(0, 0, 4'b1001, 1, 0, 1, PH_DEC);
        add_vec(0, 0, 4'b1001, 1, 0, 1, PH_NOT);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F1);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F2);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F3);
        add_vec(0, 1, 4'b1010, 0, 1, 1, PH_DEC);
        add_vec(0, 1, 4'hF, 0, 0, 1, PH_F1);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F2);
        add_vec(0, 0, 4'hF, 0, 0, 1, PH_F3);
        add_vec(0, 0, 4'b1100, 0, 0, 1, PH_DEC);
        add_vec(0, 0, 4'b1100, 0, 0, 1, PH_JMP);
        add_vec(0, 0, 4'hF, 0, 0, 0, PH_F1);

        Reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].run, vecs[i].cont, vecs[i].op,
                          vecs[i].ir5, vecs[i].ben, vecs[i].mr);
            tick($sformatf("vec%0d", i), expect_of(vecs[i].ph, vecs[i].ir5));
        end

        // Branch not taken then taken, and an unsupported opcode as a NOP
        reset_and_start();
        run_instr(4'b0000, 1'b0, 1'b0, 0, 0, 0, 0);
        run_instr(4'b0000, 1'b0, 1'b1, 0, 0, 0, 0);
        run_instr(4'b1010, 1'b0, 1'b0, 1, 0, 0, 0);

        // LDR with three stalled cycles in the read wait
        mem_rd_cycles = 0;
        ld_mdr_cycles = 0;
        run_instr(4'b0110, 1'b1, 1'b0, 0, 3, 0, 0);
        check_count("ldr_mem_rd_cycles", mem_rd_cycles, 5);
        check_count("ldr_ld_mdr_cycles", ld_mdr_cycles, 5);

        // Pause: Continue held for ten cycles then released gives one instruction
        run_instr(4'b1101, 1'b0, 1'b0, 0, 0, 2, 9);
        gate_pc_cycles = 0;
        cur_op = 4'b1101;
        step("pause_again_f1", PH_F1, 1'b1, 1'b0);
        step("pause_again_f2", PH_F2, 1'b1, 1'b0);
        step("pause_again_f3", PH_F3, 1'b1, 1'b0);
        step("pause_again_dec", PH_DEC, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step("pause_parked", PH_IDLE, 1'b1, 1'b0);
        check_count("pause_fetch_entries", gate_pc_cycles, 1);

        // Reset asserted in the middle of a stalled store write
        reset_and_start();
        cur_op = 4'b0111; cur_ir5 = 1'b0; cur_ben = 1'b0;
        step("s_fetch1", PH_F1, 1'b0, 1'b0);
        step("s_fetch2", PH_F2, 1'b1, 1'b0);
        step("s_fetch3", PH_F3, 1'b0, 1'b0);
        step("s_decode", PH_DEC, 1'b0, 1'b0);
        step("s_str1", PH_ADR, 1'b0, 1'b0);
        step("s_str2", PH_STR2, 1'b0, 1'b0);
        step("s_str3_wait", PH_STR3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("reset_in_str3", expect_of(PH_IDLE, 1'b0));
        @(posedge Clk);
        #1;
        applyStimulus(1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1);
        tick("reset_low_edge", expect_of(PH_IDLE, 1'b0));
        Reset = 1'b1;
        tick("released_no_run1", expect_of(PH_IDLE, 1'b0));
        tick("released_no_run2", expect_of(PH_IDLE, 1'b0));
        applyStimulus(1'b1, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1);
        tick("released_run", expect_of(PH_IDLE, 1'b0));
        applyStimulus(1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b1);
        tick("restart_fetch1", expect_of(PH_F1, 1'b0));
        applyStimulus(1'b0, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
        tick("restart_fetch2", expect_of(PH_F2, 1'b0));

        // Random instruction stream with random stalls and pause hold times
        reset_and_start();
        for (int n = 0; n < 200; n++) begin
            run_instr(4'($urandom_range(0, 15)), rbit(), rbit(),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
